im_fetch_ctrl: RTL and testbench
================================

Name: im_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the combinational instruction memory (word-indexed, byte-addressed PC in, instruction out in the same cycle).
- Owns the fetch PC, issues one IM read per cycle, and buffers fetched instruction/PC pairs in a 2-entry queue toward decode with valid/ready.
- Handles branch/jump redirects (flush) and out-of-range/misaligned PC faults.

Parameters:
- RESET_PC, 32'h0000_3000, byte address of the first fetch after reset.
- IM_WORDS, 4096, number of words in the instruction memory; legal PCs are RESET_PC .. RESET_PC+4*IM_WORDS-4.
- Q_DEPTH, 2, fetch queue entries (fixed at 2; other values unsupported).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- im_addr  out  32  byte address presented to the IM; equals the PC register (combinational).
- im_data  in  32  IM read data for im_addr, valid in the same cycle.
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target byte address.
- id_ready  in  1  decode accepts the head entry this cycle.
- if_valid  out  1  queue head is valid.
- if_instr  out  32  head instruction.
- if_pc  out  32  byte PC of the head instruction.
- fault  out  1  sticky fetch fault; fetching stopped.

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, queue empty, count=0, state=RUN. Outputs: if_valid=0, if_instr=0, if_pc=0, fault=0, im_addr=RESET_PC.
- States: RUN (fetching), FAULT (not fetching).
- pop = if_valid & id_ready.
- push = (state==RUN) & pc_legal & (count<2 | pop) & ~redirect_valid.
- pc_legal: pc[1:0]==0 and RESET_PC <= pc < RESET_PC+4*IM_WORDS. Compare unsigned, 32-bit, no wrap.
- push: enqueue {im_data, pc} at tail; pc <= pc+4.
- RUN with ~pc_legal and no redirect: state <= FAULT at the edge. No enqueue. pc holds. fault=1 from the next cycle.
- FAULT: no push. Queue keeps draining via pop. pc holds.
- redirect_valid (any state) has highest priority:
  - queue cleared (count=0, if_valid=0 next cycle), so pop that cycle is ignored by the queue.
  - pc <= redirect_pc; state <= RUN; fault cleared.
  - If redirect_pc is illegal, the next cycle re-enters FAULT per the rule above.
- Latency:
  - Reset release → if_valid=1 after the first rising edge.
  - Redirect edge → one cycle with if_valid=0 → valid after the next edge with if_pc=redirect_pc.
- Full (count=2) with pop: push allowed; count stays 2. Full without pop: push=0, pc holds, im_addr stable.
- Empty with push and id_ready: no bypass; the entry appears next cycle.
- Queue order is FIFO. The head is stable while if_valid & ~id_ready (decode may sample across stalls).
- pc+4 reaching RESET_PC+4*IM_WORDS is treated as illegal → FAULT. No wrap to RESET_PC.
- Reset mid-operation: immediate return to reset values regardless of state or queue contents.

Decomposition:
- Package if_pkg:
  - RESET_PC and IM_WORDS defaults.
  - state enum {RUN, FAULT}.
  - fetch entry struct {instr[31:0], pc[31:0]}.
- Sub-module fetch_queue:
  - 2-entry FIFO with push, pop, flush, count, head outputs.
  - Same clk/reset_n.
  - Flush has priority over push/pop.
- im_fetch_ctrl holds the PC, legality check, and state machine.

Test Plan:
- Reset release, id_ready=1, IM word i = 32'h1000_0000+i → if_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles, if_instr matching; if_valid=1 from the first edge.
- id_ready=0 for 4 cycles after start → count saturates at 2 with heads 0x3000/0x3004; im_addr holds 0x3008. Release → 0x3000, 0x3004, 0x3008 in order with no loss or duplicate.
- Redirect to 0x3100 while the queue is full and id_ready=1 → next cycle if_valid=0, then if_pc=0x3100; no pre-redirect entry is ever presented after the flush.
- Redirect to 0x3102 (misaligned) → one cycle later fault=1, if_valid=0, im_addr=0x3102. Redirect to 0x3000 → fault=0, if_pc=0x3000 valid after two edges.
- IM_WORDS=4, run from reset → entries 0x3000..0x300C delivered; pc=0x3010 triggers fault=1; queue drains its remaining entries before if_valid drops.
- Assert reset_n=0 mid-stream between edges → outputs go to reset values immediately (async). After release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch block.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 4096;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instruction/PC pairs; flush beats push/pop.
module fetch_queue
    import if_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop & (cnt_q != 2'd0);
    assign do_push = push & ((cnt_q != 2'd2) | do_pop);

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = din;
                    end else begin
                        e0_d = e1_q;
                        e1_d = din;
                    end
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = din;
                    else               e1_d = din;
                    cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head  = e0_q;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Fetch sequencer: owns the PC, checks legality, feeds the fetch queue.
module im_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault
);

    // 33-bit end bound so the top of the window cannot wrap
    localparam logic [32:0] PC_END =
        {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

    state_e       state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pc_legal;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t din;

    assign pc_legal = (pc_q[1:0] == 2'b00)
                    && (pc_q >= RESET_PC)
                    && ({1'b0, pc_q} < PC_END);

    assign pop  = if_valid & id_ready;
    assign push = (state_q == RUN) & pc_legal
                & ((count != 2'd2) | pop)
                & ~redirect_valid;

    assign din.instr = im_data;
    assign din.pc    = pc_q;

    fetch_queue u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .din     (din),
        .count   (count),
        .head    (head)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = redirect_pc;
        end else if (state_q == RUN) begin
            if (!pc_legal)  state_d = FAULT;
            else if (push)  pc_d    = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign im_addr  = pc_q;
    assign if_valid = (count != 2'd0);
    assign if_instr = if_valid ? head.instr : 32'd0;
    assign if_pc    = if_valid ? head.pc : 32'd0;
    assign fault    = (state_q == FAULT);

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl against a queue-based fetch model.
module tb_im_fetch_ctrl;

    localparam logic [31:0] RPC   = 32'h0000_3000;
    localparam int          WORDS = 128;
    localparam longint      ENDPC = 64'h3000 + 4 * WORDS;

    logic        clk;
    logic        reset_n;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;

    im_fetch_ctrl #(
        .RESET_PC (RPC),
        .IM_WORDS (WORDS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .im_addr        (im_addr),
        .im_data        (im_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + ((a - RPC) >> 2);
    endfunction

    assign im_data = mem(im_addr);

    typedef struct {
        bit          v;
        bit          f;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    exp_t        exp_q[$];
    ent_t        mq[$];
    logic [31:0] mpc;
    bit          mfault;
    int          tests;
    int          fails;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, want, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= RPC)
            && (longint'(a) < ENDPC);
    endfunction

    function automatic void model_reset();
        mq.delete();
        mpc    = RPC;
        mfault = 1'b0;
    endfunction

    // One clock edge of the fetch rules, using the inputs held this cycle
    function automatic void model_step();
        ent_t e;
        if (redirect_valid) begin
            mq.delete();
            mpc    = redirect_pc;
            mfault = 1'b0;
            return;
        end
        if (mq.size() > 0 && id_ready) void'(mq.pop_front());
        if (!mfault) begin
            if (!legal(mpc)) begin
                mfault = 1'b1;
            end else if (mq.size() < 2) begin
                e.pc    = mpc;
                e.instr = mem(mpc);
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    endfunction

    task automatic cycle(input bit rdy,
                         input bit rv = 1'b0,
                         input logic [31:0] rpc = 32'd0);
        exp_t x;
        @(posedge clk);
        model_step();
        #2;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        x.v    = (mq.size() > 0);
        x.f    = mfault;
        x.addr = mpc;
        x.pc    = x.v ? mq[0].pc : 32'd0;
        x.instr = x.v ? mq[0].instr : 32'd0;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("if_valid", {31'd0, if_valid}, {31'd0, e.v});
            chk("fault", {31'd0, fault}, {31'd0, e.f});
            chk("im_addr", im_addr, e.addr);
            if (e.v) begin
                chk("if_pc", if_pc, e.pc);
                chk("if_instr", if_instr, e.instr);
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_addr", im_addr, RPC);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
    endtask

    function automatic logic [31:0] rand_target();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 5)
            return RPC + 4 * $urandom_range(0, WORDS - 1);
        if (sel == 6)
            return RPC + 4 * (WORDS - $urandom_range(1, 3));
        if (sel == 7)
            return RPC + 4 * $urandom_range(0, WORDS - 1)
                 + $urandom_range(1, 3);
        if (sel == 8)
            return RPC - 4 * $urandom_range(1, 8);
        return (sel == 9 && $urandom_range(0, 1) == 1)
             ? 32'hFFFF_FFFC : ENDPC[31:0];
    endfunction

    initial begin
        tests          = 0;
        fails          = 0;
        reset_n        = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        model_reset();
        #13;
        chk_reset_vals();
        #4 reset_n = 1'b1;

        // Streaming from reset, then a 4-cycle decode stall
        repeat (6) cycle(1'b1);
        repeat (4) cycle(1'b0);
        repeat (4) cycle(1'b1);
        repeat (2) cycle(1'b0);

        // Redirect while full, then misaligned, then back to start
        cycle(1'b1, 1'b1, 32'h0000_3100);
        repeat (5) cycle(1'b1);
        cycle(1'b1, 1'b1, 32'h0000_3102);
        repeat (4) cycle(1'b1);
        cycle(1'b1, 1'b1, 32'h0000_3000);
        repeat (4) cycle(1'b1);

        // Run off the end of the memory window with a slow drain
        cycle(1'b0, 1'b1, RPC + 4 * (WORDS - 4));
        repeat (8) cycle(1'b0);
        repeat (6) cycle(1'b1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                cycle($urandom_range(0, 3) != 0, 1'b1, rand_target());
            else
                cycle($urandom_range(0, 3) != 0);
        end

        // Asynchronous reset in the middle of a cycle
        repeat (3) cycle(1'b0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk_reset_vals();
        redirect_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (8) cycle(1'b1);
        @(posedge clk);
        #6;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
